// File: rtl/pulse_width_rx.sv
// pulse_width_rx
//   Measures the high time of each pulse on a clk-synchronous input, in clock
//   cycles. Pulses shorter than MIN_W are rejected with a glitch strobe;
//   pulses longer than the counter range saturate and flag overflow.
//   Accepted pulses are counted in pulse_cnt.
//
//   state   | meaning
//   IDLE    | waiting for a 0->1 transition on din
//   MEASURE | din high, counting high samples
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   pulse input, already synchronous to clk
//   clr       in   synchronous clear of pulse_cnt
//   width     out  high time of the last accepted pulse (saturates at max)
//   valid     out  one-cycle strobe, width/overflow updated
//   overflow  out  last accepted pulse saturated; held until next valid
//   glitch    out  one-cycle strobe, short pulse rejected
//   busy      out  high while measuring
//   pulse_cnt out  accepted-pulse count, wraps silently
module pulse_width_rx #(
  parameter int CNT_W  = 8,
  parameter int MIN_W  = 2,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              clr,
  output logic [CNT_W-1:0]  width,
  output logic              valid,
  output logic              overflow,
  output logic              glitch,
  output logic              busy,
  output logic [PCNT_W-1:0] pulse_cnt
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_W);

  state_t            state;
  logic              din_d;
  logic [CNT_W-1:0]  cnt;
  logic              sat;
  logic              rise;
  logic [PCNT_W-1:0] pcnt_base;

  assign rise = din & ~din_d;

  // clr takes effect first so an accept on the same edge still counts.
  assign pcnt_base = clr ? '0 : pulse_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      // Resetting high means a din already high at release is never measured.
      din_d     <= 1'b1;
      cnt       <= '0;
      sat       <= 1'b0;
      width     <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      glitch    <= 1'b0;
      busy      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      din_d     <= din;
      valid     <= 1'b0;
      glitch    <= 1'b0;
      pulse_cnt <= pcnt_base;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (din) begin
            if (cnt == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            sat   <= 1'b0;
            cnt   <= '0;
            if (cnt >= MIN_CNT) begin
              width     <= cnt;
              overflow  <= sat;
              valid     <= 1'b1;
              pulse_cnt <= pcnt_base + PCNT_W'(1);
            end else begin
              glitch <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_rx.sv
// tb_pulse_width_rx
//   Directed and randomized stimulus for pulse_width_rx. Expected outputs come
//   from a pulse-level reference model: it tracks the length of the current
//   high run since a qualifying 0->1 transition and applies the accept,
//   reject and saturate rules to that length.
module tb_pulse_width_rx;

  localparam int CNT_W  = 8;
  localparam int MIN_W  = 2;
  localparam int PCNT_W = 16;
  localparam int W_MAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              din;
  logic              clr;
  logic [CNT_W-1:0]  width;
  logic              valid;
  logic              overflow;
  logic              glitch;
  logic              busy;
  logic [PCNT_W-1:0] pulse_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic              m_prev;
  int                m_run;
  int                m_width;
  logic              m_ovf;
  logic [PCNT_W-1:0] m_pcnt;

  pulse_width_rx #(.CNT_W(CNT_W), .MIN_W(MIN_W), .PCNT_W(PCNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .clr       (clr),
    .width     (width),
    .valid     (valid),
    .overflow  (overflow),
    .glitch    (glitch),
    .busy      (busy),
    .pulse_cnt (pulse_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b1;
    m_run   = 0;
    m_width = 0;
    m_ovf   = 1'b0;
    m_pcnt  = '0;
  endtask

  // Apply one clock with the given inputs, advance the model, compare.
  task automatic step(input logic d, input logic c);
    logic exp_valid, exp_glitch;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
    exp_valid  = 1'b0;
    exp_glitch = 1'b0;
    if (m_run > 0) begin
      if (d) begin
        m_run++;
      end else begin
        if (m_run >= MIN_W) begin
          m_width   = (m_run > W_MAX) ? W_MAX : m_run;
          m_ovf     = (m_run > W_MAX);
          exp_valid = 1'b1;
        end else begin
          exp_glitch = 1'b1;
        end
        m_run = 0;
      end
    end else if (d && !m_prev) begin
      m_run = 1;
    end
    if (c) m_pcnt = '0;
    if (exp_valid) m_pcnt = m_pcnt + 1'b1;
    m_prev = d;
    chk("valid",     valid,     exp_valid);
    chk("glitch",    glitch,    exp_glitch);
    chk("width",     width,     m_width);
    chk("overflow",  overflow,  m_ovf);
    chk("busy",      busy,      m_run > 0);
    chk("pulse_cnt", pulse_cnt, m_pcnt);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
  endtask

  // Assert reset away from the clock edge and check the async response.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_width",     width,     0);
    chk("rst_valid",     valid,     0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_glitch",    glitch,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_pulse_cnt", pulse_cnt, 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int hi, lo;
    rst_n = 1'b1;
    din   = 1'b0;
    clr   = 1'b0;
    model_reset();
    #2;
    apply_reset(5);

    // Single-cycle glitch
    pulse(0, 2);
    pulse(1, 15);

    // Nominal 5-cycle pulse
    pulse(5, 3);

    // Back-to-back 3 and 4 with one low cycle between
    pulse(3, 1);
    pulse(4, 3);

    // Saturation, then recovery
    pulse(300, 2);
    pulse(5, 2);

    // Saturation boundary: 255 fits, 256 overflows
    pulse(255, 1);
    pulse(256, 2);
    pulse(2, 2);

    // din already high across reset release is not measured
    din = 1'b1;
    apply_reset(3);
    pulse(3, 2);
    pulse(3, 2);

    // Reset mid-pulse, din stays high through release
    pulse(3, 0);
    apply_reset(2);
    pulse(2, 2);
    pulse(4, 2);

    // clr coincident with an accept
    pulse(4, 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // clr with no accept
    step(1'b0, 1'b1);
    pulse(3, 2);

    // Randomized pulses with occasional clr
    for (int k = 0; k < 60; k++) begin
      hi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 300))
                                        : int'($urandom_range(1, 8));
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi; i++) step(1'b1, $urandom_range(0, 15) == 0);
      for (int i = 0; i < lo; i++) step(1'b0, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
